image_scanner: RTL and testbench

- Raster-scan read initiator for the image ROM path.
- On a start pulse it walks (x, y) over the whole image and drives coordinate requests to the pixel memory.
- It captures each returned pixel and streams it downstream over a valid/ready interface, with sof/eol/eof framing.
- It sits between the image memory and the processing pipeline, and is the read-side counterpart to the coordinate-addressed image store.

---
 rtl/image_pkg.sv | 17 +
 rtl/image_scanner_raster_counter.sv | 51 +++++
 rtl/image_scanner.sv | 166 ++++++++++++++++
 tb/tb_image_scanner.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared types and default geometry for the image read/write path.
package image_pkg;

  localparam int IMG_WIDTH_DEF  = 4;
  localparam int IMG_HEIGHT_DEF = 4;
  localparam int COORD_W_DEF    = 4;
  localparam int PIX_W_DEF      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

endpackage

// File: rtl/image_scanner_raster_counter.sv
// Raster x/y counter with advance and clear; flags the last column and the last pixel of the frame.
module raster_counter #(
  parameter int WIDTH   = 4,
  parameter int HEIGHT  = 4,
  parameter int COORD_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_adv,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_last_in_line,
  output logic               o_last_in_frame
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               w_last_line;
  logic               w_last_frame;

  assign w_last_line  = (r_x == X_LAST);
  assign w_last_frame = w_last_line && (r_y == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      if (w_last_line) begin
        r_x <= '0;
        // Wrapping at the frame end leaves the counter ready for the next frame.
        r_y <= w_last_frame ? '0 : r_y + COORD_W'(1);
      end else begin
        r_x <= r_x + COORD_W'(1);
      end
    end
  end

  assign o_x             = r_x;
  assign o_y             = r_y;
  assign o_last_in_line  = w_last_line;
  assign o_last_in_frame = w_last_frame;

endmodule

// File: rtl/image_scanner.sv
// Raster-scan read initiator: requests (x, y) from pixel memory and streams pixels with sof/eol/eof.
// Optional frame checksum output enabled by defining IMAGE_SCANNER_CHECKSUM_EN.
module image_scanner
  import image_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int PIX_W      = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic [COORD_W-1:0] x_req,
  output logic [COORD_W-1:0] y_req,
  input  logic [PIX_W-1:0]   pixel_in,
  input  logic               pixel_in_valid,
  output logic [PIX_W-1:0]   out_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic               out_eol,
  output logic               out_eof,
  output logic               busy,
  output logic               done,
  output logic [7:0]         frame_count
`ifdef IMAGE_SCANNER_CHECKSUM_EN
  ,
  output logic [15:0]        checksum
`endif
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_pop;
  logic               w_frame_done;
  logic               w_clr;
  logic               w_last_line;
  logic               w_last_frame;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;

  logic [PIX_W-1:0]   r_out_pixel;
  logic               r_out_valid;
  logic               r_sof;
  logic               r_eol;
  logic               r_eof;
  logic               r_done;
  logic [7:0]         r_frame_count;

  // Coordinates are only live while scanning; every other state parks them at the origin.
  assign w_clr = abort || (r_state != SCAN);

  raster_counter #(
    .WIDTH  (IMG_WIDTH),
    .HEIGHT (IMG_HEIGHT),
    .COORD_W(COORD_W)
  ) u_raster (
    .clk            (clk),
    .rst_n          (reset),
    .i_clr          (w_clr),
    .i_adv          (w_load),
    .o_x            (w_x),
    .o_y            (w_y),
    .o_last_in_line (w_last_line),
    .o_last_in_frame(w_last_frame)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_frame_done = 1'b0;
    w_pop        = r_out_valid && out_ready;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) w_state_nxt = SCAN;
        end
        SCAN: begin
          // The output register is free when empty or being drained this cycle.
          w_load = pixel_in_valid && (!r_out_valid || out_ready);
          if (w_load && w_last_frame) w_state_nxt = DRAIN;
        end
        DRAIN: begin
          if (w_pop) begin
            w_frame_done = 1'b1;
            w_state_nxt  = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_pixel   <= '0;
      r_out_valid   <= 1'b0;
      r_sof         <= 1'b0;
      r_eol         <= 1'b0;
      r_eof         <= 1'b0;
      r_done        <= 1'b0;
      r_frame_count <= '0;
    end else if (abort) begin
      r_out_pixel <= '0;
      r_out_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_eof       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_frame_done;
      if (w_frame_done) r_frame_count <= r_frame_count + 8'd1;
      if (w_load) begin
        r_out_pixel <= pixel_in;
        r_out_valid <= 1'b1;
        r_sof       <= (w_x == '0) && (w_y == '0);
        r_eol       <= w_last_line;
        r_eof       <= w_last_frame;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef IMAGE_SCANNER_CHECKSUM_EN
  logic [15:0] r_checksum;

  // Sums beats as they are accepted downstream; nothing is accepted after done, so the sum holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if (abort || ((r_state == IDLE) && start)) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum + 16'(r_out_pixel);
    end
  end

  assign checksum = r_checksum;
`endif

  assign x_req       = w_x;
  assign y_req       = w_y;
  assign out_pixel   = r_out_pixel;
  assign out_valid   = r_out_valid;
  assign out_sof     = r_sof;
  assign out_eol     = r_eol;
  assign out_eof     = r_eof;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_image_scanner.sv
// Scoreboard bench for image_scanner: a frame-level model pushes expected beats, a monitor pops on handshakes.
`timescale 1ns/1ps
module tb_image_scanner;
  import image_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int CW = 4;
  localparam int PW = 8;

  typedef struct packed {
    logic [PW-1:0] pix;
    logic          sof;
    logic          eol;
    logic          eof;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] x_req;
  logic [CW-1:0] y_req;
  logic [PW-1:0] pixel_in;
  logic          pixel_in_valid;
  logic [PW-1:0] out_pixel;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic          busy;
  logic          done;
  logic [7:0]    frame_count;
`ifdef IMAGE_SCANNER_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  image_scanner #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .COORD_W   (CW),
    .PIX_W     (PW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .x_req         (x_req),
    .y_req         (y_req),
    .pixel_in      (pixel_in),
    .pixel_in_valid(pixel_in_valid),
    .out_pixel     (out_pixel),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sof       (out_sof),
    .out_eol       (out_eol),
    .out_eof       (out_eof),
    .busy          (busy),
    .done          (done),
    .frame_count   (frame_count)
`ifdef IMAGE_SCANNER_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Pixel memory: combinational response at the requested coordinate.
  pixel_t mem [N];
  always_comb pixel_in = mem[4'(int'(y_req) * W + int'(x_req))];

  int     checks = 0;
  int     errors = 0;
  beat_t  exp_q[$];
  int     beats_seen = 0;
  int     dones_seen = 0;
  int     exp_dones = 0;
  logic [7:0]  exp_frames = 8'd0;
  logic [15:0] exp_sum = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops on each accepted beat and checks stalled beats stay put.
  initial begin
    logic  prev_stall;
    logic  prev_abort;
    beat_t prev_beat;
    beat_t b;
    prev_stall = 1'b0;
    prev_abort = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !prev_abort) begin
          chk("stall_valid_hold", 32'(out_valid), 32'd1);
          chk("stall_beat_hold", 32'({out_pixel, out_sof, out_eol, out_eof}), 32'(prev_beat));
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat actual=%0d required=none", out_pixel);
          end else begin
            b = exp_q.pop_front();
            if ({out_pixel, out_sof, out_eol, out_eof} !== b) begin
              errors++;
              $display("FAIL beat actual=%0d/%b%b%b required=%0d/%b%b%b",
                       out_pixel, out_sof, out_eol, out_eof, b.pix, b.sof, b.eol, b.eof);
            end
          end
          beats_seen++;
        end
        if (done) dones_seen++;
        prev_stall = out_valid && !out_ready;
        prev_abort = abort;
        prev_beat  = {out_pixel, out_sof, out_eol, out_eof};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference: a frame is the memory read in raster order with framing derived from the index.
  task automatic start_frame();
    beat_t b;
    exp_sum = 16'd0;
    for (int i = 0; i < N; i++) begin
      b.pix = mem[i];
      b.sof = (i == 0);
      b.eol = ((i % W) == W - 1);
      b.eof = (i == N - 1);
      exp_q.push_back(b);
      exp_sum = exp_sum + 16'(mem[i]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_until_idle(input int mode, input string nm);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 600) begin
      case (mode)
        1:       begin out_ready = (k % 4 == 0) || (k % 4 == 3); pixel_in_valid = 1'b1; end
        2:       begin out_ready = ($urandom_range(0, 3) != 0); pixel_in_valid = ($urandom_range(0, 3) != 0); end
        default: begin out_ready = 1'b1; pixel_in_valid = 1'b1; end
      endcase
      tick();
      k++;
    end
    if (k >= 600) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle", nm);
    end
    out_ready      = 1'b1;
    pixel_in_valid = 1'b1;
  endtask

  task automatic finish_frame(input string nm);
    exp_frames = exp_frames + 8'd1;
    exp_dones++;
    tick();
    chk({nm, "_frame_count"}, 32'(frame_count), 32'(exp_frames));
    chk({nm, "_done_pulses"}, 32'(dones_seen), 32'(exp_dones));
    chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
`ifdef IMAGE_SCANNER_CHECKSUM_EN
    chk({nm, "_checksum"}, 32'(checksum), 32'(exp_sum));
`endif
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_out_pixel"}, 32'(out_pixel), 32'd0);
    chk({nm, "_flags"}, 32'({out_sof, out_eol, out_eof}), 32'd0);
    chk({nm, "_coords"}, 32'({x_req, y_req}), 32'd0);
    chk({nm, "_busy_done"}, 32'({busy, done}), 32'd0);
    chk({nm, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    int dones_before;
    logic [7:0] fc;
    logic [PW-1:0] img [N] = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd32, 8'd96, 8'd160, 8'd224,
                               8'd16, 8'd80, 8'd144, 8'd208, 8'd48, 8'd112, 8'd176, 8'd255};
    for (int i = 0; i < N; i++) mem[i] = img[i];
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; pixel_in_valid = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Reference frame, no stalls: beats in cycles 2..17, done in cycle 18.
    start_frame();
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_valid_c1", 32'(out_valid), 32'd0);
`ifdef IMAGE_SCANNER_CHECKSUM_EN
    chk("t1_checksum_cleared", 32'(checksum), 32'd0);
`endif
    for (int c = 2; c <= 18; c++) begin
      tick();
      if (c <= 17) chk("t1_valid_stream", 32'(out_valid), 32'd1);
      if (c == 17) chk("t1_eof_beat", 32'({out_pixel, out_eof}), 32'({8'd255, 1'b1}));
      if (c == 18) chk("t1_done_c18", 32'({done, out_valid}), 32'({1'b1, 1'b0}));
    end
    finish_frame("t1");

    // Backpressure 1,0,0,1.
    start_frame();
    drive_until_idle(1, "t2");
    finish_frame("t2");

    // pixel_in_valid low in cycles 4..6.
    start_frame();
    for (int c = 1; c <= 7; c++) begin
      pixel_in_valid = !(c >= 4 && c <= 6);
      if (c >= 4 && c <= 6) chk("t3_coord_hold", 32'({x_req, y_req}), 32'({4'd3, 4'd0}));
      if (c >= 5) chk("t3_no_beat", 32'(out_valid), 32'd0);
      tick();
    end
    drive_until_idle(0, "t3");
    finish_frame("t3");

    // Abort after the fifth beat, then rescan.
    start_frame();
    base = beats_seen;
    k = 0;
    while (beats_seen < base + 5 && k < 100) begin tick(); k++; end
    chk("t4_reached_beat5", 32'(beats_seen - base), 32'd5);
    fc = frame_count;
    dones_before = dones_seen;
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    chk("t4_abort_valid", 32'(out_valid), 32'd0);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    chk("t4_abort_coords", 32'({x_req, y_req}), 32'd0);
`ifdef IMAGE_SCANNER_CHECKSUM_EN
    chk("t4_abort_checksum", 32'(checksum), 32'd0);
`endif
    repeat (3) tick();
    chk("t4_no_done", 32'(dones_seen), 32'(dones_before));
    chk("t4_fc_unchanged", 32'(frame_count), 32'(fc));
    start_frame();
    drive_until_idle(0, "t4");
    finish_frame("t4");

    // Abort and start together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_abort_beats_start", 32'(busy), 32'd0);
    tick();
    chk("t5_still_idle", 32'({busy, out_valid}), 32'd0);

    // Asynchronous reset mid-frame.
    start_frame();
    repeat (7) tick();
    reset = 1'b0;
    #1;
    check_all_zero("t6_reset");
    exp_q.delete();
    exp_frames = 8'd0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    start_frame();
    drive_until_idle(0, "t6");
    finish_frame("t6");

    // Randomized images and handshakes.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
      start_frame();
      drive_until_idle(2, "rnd");
      finish_frame("rnd");
    end

    // Run the frame counter through its wrap.
    while (exp_frames != 8'd0) begin
      start_frame();
      drive_until_idle(0, "wrap");
      finish_frame("wrap");
    end
    chk("wrap_frame_count_zero", 32'(frame_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
